validity_pair_gen: RTL
======================

# validity_pair_gen

Burst generator for the redundant-lane checking path: emits a programmable number of 3-bit word pairs on two lanes, optionally corrupting lane 1 at one chosen index, and scores the downstream equality checker's registered verdict against the expected outcome. Sits upstream of the lane-equality checker in the perf_sys self-test path. The checker's one-bit result is fed back so the block reports how often the checker disagreed with the expected verdict.

## Interface
- LEN, 16: pairs per burst; legal range 1 .. 2^CNT_W-1
- CNT_W, 8: width of the index, inject_idx and err_count fields

- clk  in  1  sole clock; all state on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request a burst; honoured only in IDLE
- inject_en  in  1  corrupt one pair in this burst; sampled when start is accepted
- inject_idx  in  CNT_W  index of the pair to corrupt; sampled when start is accepted
- valid_in  in  1  checker's registered equality verdict; 1 = lanes matched
- out0  out  3  lane 0 word
- out1  out  3  lane 1 word
- out_valid  out  1  a pair is presented on out0/out1 this cycle
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when a burst completes
- err_count  out  CNT_W  number of checker verdicts that differed from expectation; saturates

## Operation
- Reset values: out0=0, out1=0, out_valid=0, busy=0, done=0, err_count=0, state IDLE, index=0.
- States: IDLE -> RUN on start. RUN -> DRAIN after pair LEN-1 is presented. DRAIN -> DONE after one cycle. DONE -> IDLE after one cycle.
- Start accepted in IDLE: err_count cleared; inject_en and inject_idx latched; index=0; word generator seeded.
- start in RUN, DRAIN or DONE is ignored; nothing is latched.
- Pair k: out0 = generator word k. out1 = out0 normally. If the latched inject_en=1 and k == latched inject_idx, out1 = out0 ^ 3'b001.
- Expected verdict for pair k is 0 if pair k is corrupted, otherwise 1.
- If inject_idx >= LEN, no pair is corrupted.
- Scoring pipeline: chk_d <= out_valid and exp_d <= expected verdict of the pair currently presented.
- Scoring: on each edge where chk_d=1, increment err_count when valid_in != exp_d. err_count saturates at 2^CNT_W-1.
- Outside RUN, out0 and out1 hold their last values and out_valid=0.
- Reset asserted at any point, including mid-burst, aborts immediately to the reset values. No done pulse is produced.

## Timing
- All outputs are registered.
- If start is accepted at the edge ending cycle N:
  - pair k is presented in cycle N+1+k, with out_valid=1 for cycles N+1 .. N+LEN;
  - DRAIN is cycle N+LEN+1;
  - done=1 in cycle N+LEN+2;
  - busy=1 for cycles N+1 .. N+LEN+1.
- Checker latency is fixed at 1: the verdict for pair k must be valid on valid_in in cycle N+2+k.
- Exactly LEN verdicts are scored, in cycles N+2 .. N+LEN+1.
- err_count is final and stable once done is high, and holds until the next accepted start.
- start may be asserted in the same cycle as done; it is ignored. The earliest accepted start is in the first IDLE cycle, N+LEN+3.

## Configuration
- VALIDITY_GEN_LFSR_EN defined:
  - generator is a 3-bit Fibonacci LFSR, seed 3'b001;
  - next = {cur[1:0], cur[2]^cur[1]};
  - sequence 001, 010, 101, 011, 111, 110, 100, then repeats with period 7.
- Undefined: out0 = k[2:0], an incrementing counter that wraps 7 -> 0.
- Injection, scoring and timing are identical in both builds.

## Test plan
- Clean burst: LEN=16, ideal checker model, inject_en=0, start at N -> out1==out0 on all 16 pairs, done at N+18, err_count=0.
- Injection: inject_en=1, inject_idx=5, ideal checker -> only pair 5 has out1=out0^001; err_count=0.
- Checker stuck at 1: inject at idx 5 -> err_count=1. Checker stuck at 0, no inject -> err_count=16.
- Out-of-range injection: inject_idx=20 with LEN=16 -> no corruption; err_count=0.
- Reset pulse at pair 7, then start ignored during busy -> all outputs return to reset values with no done pulse. Start asserted during busy is ignored: the burst length stays 16.
- Macro build check:
  - with VALIDITY_GEN_LFSR_EN, out0 = 001, 010, 101, 011, 111, 110, 100, 001, ...;
  - without it, out0 = 0..7, 0..7.

Source files
------------

// File: rtl/validity_pair_gen.sv
// Burst generator for the redundant-lane checking path: emits LEN word pairs, optionally corrupts
// lane 1 at one index, and scores the checker's verdicts. Define VALIDITY_GEN_LFSR_EN for LFSR words.
module validity_pair_gen #(
  parameter int LEN   = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             inject_en,
  input  logic [CNT_W-1:0] inject_idx,
  input  logic             valid_in,
  output logic [2:0]       out0,
  output logic [2:0]       out1,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;

`ifdef VALIDITY_GEN_LFSR_EN
  localparam logic [2:0] SEED = 3'b001;

  function automatic logic [2:0] gen_next(input logic [2:0] cur);
    return {cur[1:0], cur[2] ^ cur[1]};
  endfunction
`else
  localparam logic [2:0] SEED = 3'b000;

  function automatic logic [2:0] gen_next(input logic [2:0] cur);
    return cur + 3'd1;
  endfunction
`endif

  state_t           state, next_state;
  logic [CNT_W-1:0] index, idx_nxt;
  logic [CNT_W-1:0] inj_idx_q;
  logic             inj_en_q;
  logic             corrupt_q, corrupt_nxt;
  logic [2:0]       word_nxt;
  logic             out_valid_nxt, busy_nxt, done_nxt;
  logic             chk_d, exp_d;
  logic             accept, last;

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (index == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = RUN;
      RUN:   if (last)  next_state = DRAIN;
      DRAIN: next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode: values the registered outputs take on the next edge.
  always_comb begin
    out_valid_nxt = (next_state == RUN);
    busy_nxt      = (next_state == RUN) || (next_state == DRAIN);
    done_nxt      = (next_state == DONE);
    idx_nxt       = index;
    word_nxt      = out0;
    corrupt_nxt   = corrupt_q;
    if (accept) begin
      idx_nxt     = '0;
      word_nxt    = SEED;
      corrupt_nxt = inject_en && (inject_idx == '0);
    end else if ((state == RUN) && !last) begin
      idx_nxt     = index + ONE;
      word_nxt    = gen_next(out0);
      corrupt_nxt = inj_en_q && (inj_idx_q == idx_nxt);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index     <= '0;
      inj_en_q  <= 1'b0;
      inj_idx_q <= '0;
      corrupt_q <= 1'b0;
      out0      <= '0;
      out1      <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (accept) begin
        inj_en_q  <= inject_en;
        inj_idx_q <= inject_idx;
      end
      index     <= idx_nxt;
      corrupt_q <= corrupt_nxt;
      out0      <= word_nxt;
      out1      <= word_nxt ^ {2'b00, corrupt_nxt};
      out_valid <= out_valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

  // The checker's verdict for the pair presented now arrives one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_d     <= 1'b0;
      exp_d     <= 1'b0;
      err_count <= '0;
    end else begin
      chk_d <= out_valid;
      exp_d <= ~corrupt_q;
      if (accept)
        err_count <= '0;
      else if (chk_d && (valid_in != exp_d) && (err_count != ERR_MAX))
        err_count <= err_count + ONE;
    end
  end

endmodule
